// File: rtl/cipherbox_pkg.sv
// Shared types and constants for the cipher box datapath (UART framing -> cipher core).
package cipherbox_pkg;

  typedef enum logic [2:0] {IDLE, MODE, DATA, CHECK, HOLD} state_t;

  localparam logic [7:0]  SOF_DEFAULT = 8'hA5;
  localparam logic [7:0]  MODE_ENC    = 8'h00;
  localparam logic [7:0]  MODE_DEC    = 8'h01;
  localparam int unsigned BLOCK_BITS  = 128;

  function automatic logic is_mode_code(input logic [7:0] b);
    return (b == MODE_ENC) || (b == MODE_DEC);
  endfunction

endpackage

// File: rtl/inter_byte_timer.sv
// Loadable down-counter guarding the gap between consecutive bytes of a frame.
module inter_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic clk,
  input  logic nrst,
  input  logic reload,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (reload) begin
      count <= CW'(TIMEOUT_CYCLES - 1);
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  // A reload in the zero cycle wins: the parent only acts on expire without a byte.
  assign expire = enable && (count == '0);

endmodule

// File: rtl/uart_block_assembler.sv
// Parses SOF/mode/data/checksum frames from the UART receiver and hands one
// assembled block with its mode to the cipher core over valid/ready.
module uart_block_assembler
  import cipherbox_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ   = 12000000,
  parameter int unsigned BLOCK_BYTES    = BLOCK_BITS / 8,
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     received,
  input  logic [7:0]               rx_byte,
  input  logic                     recv_error,
  output logic                     block_valid,
  input  logic                     block_ready,
  output logic [8*BLOCK_BYTES-1:0] block_data,
  output logic                     block_mode,
  output logic                     busy,
  output logic                     err_checksum,
  output logic                     err_timeout,
  output logic                     err_mode,
  output logic                     err_overrun,
  output logic                     err_framing
);

  localparam int unsigned BW = 8 * BLOCK_BYTES;
  localparam int unsigned IW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

  if (SYS_CLK_FREQ == 0 || BLOCK_BYTES < 2) begin : g_bad_cfg
    $error("uart_block_assembler: invalid SYS_CLK_FREQ or BLOCK_BYTES");
  end

  state_t          state, state_nxt;
  logic [7:0]      acc, acc_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [BW-1:0]   data_r, data_nxt;
  logic            mode_r, mode_nxt;
  logic            e_chk_nxt, e_to_nxt, e_mode_nxt, e_ovr_nxt, e_frm_nxt;
  logic            in_frame, accept, tmr_expire;

  assign in_frame = (state == MODE) || (state == DATA) || (state == CHECK);
  assign accept   = received && !recv_error;

  inter_byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .nrst   (nrst),
    .reload (accept),
    .enable (in_frame),
    .expire (tmr_expire)
  );

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    idx_nxt    = idx;
    data_nxt   = data_r;
    mode_nxt   = mode_r;
    e_chk_nxt  = 1'b0;
    e_to_nxt   = 1'b0;
    e_mode_nxt = 1'b0;
    e_ovr_nxt  = 1'b0;
    e_frm_nxt  = 1'b0;

    if (recv_error && in_frame) begin
      e_frm_nxt = 1'b1;
      state_nxt = IDLE;
    end else begin
      // Outside a frame a framing error is only reported; HOLD still honours the handshake.
      e_frm_nxt = recv_error;
      unique case (state)
        IDLE: begin
          if (accept && (rx_byte == SOF_BYTE)) begin
            acc_nxt   = '0;
            state_nxt = MODE;
          end
        end
        MODE: begin
          if (accept) begin
            if (is_mode_code(rx_byte)) begin
              mode_nxt  = rx_byte[0];
              acc_nxt   = rx_byte;
              idx_nxt   = '0;
              state_nxt = DATA;
            end else begin
              e_mode_nxt = 1'b1;
              state_nxt  = IDLE;
            end
          end else if (tmr_expire) begin
            e_to_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        DATA: begin
          if (accept) begin
            data_nxt = {data_r[BW-9:0], rx_byte};
            acc_nxt  = acc ^ rx_byte;
            idx_nxt  = idx + IW'(1);
            if (idx == IW'(BLOCK_BYTES - 1)) state_nxt = CHECK;
          end else if (tmr_expire) begin
            e_to_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        CHECK: begin
          if (accept) begin
            if (rx_byte == acc) begin
              state_nxt = HOLD;
            end else begin
              e_chk_nxt = 1'b1;
              state_nxt = IDLE;
            end
          end else if (tmr_expire) begin
            e_to_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        HOLD: begin
          e_ovr_nxt = accept;
          if (block_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      acc          <= '0;
      idx          <= '0;
      data_r       <= '0;
      mode_r       <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_mode     <= 1'b0;
      err_overrun  <= 1'b0;
      err_framing  <= 1'b0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      idx          <= idx_nxt;
      data_r       <= data_nxt;
      mode_r       <= mode_nxt;
      err_checksum <= e_chk_nxt;
      err_timeout  <= e_to_nxt;
      err_mode     <= e_mode_nxt;
      err_overrun  <= e_ovr_nxt;
      err_framing  <= e_frm_nxt;
    end
  end

  assign block_valid = (state == HOLD);
  assign busy        = (state != IDLE);
  assign block_data  = data_r;
  assign block_mode  = mode_r;

endmodule

// File: doc/uart_block_assembler.md
Name: uart_block_assembler

Overview:
- Consumes the byte stream from the UART receiver (`received` strobe plus `rx_byte`).
- Parses framed cipher requests of the form: SOF, mode, 16 data bytes, checksum.
- Presents one assembled 128-bit block with its mode to the cipher core over a valid/ready handshake.
- Sits directly downstream of the UART receiver and upstream of the cipher engine.

Parameters:
- SYS_CLK_FREQ, 12000000, system clock in Hz (documentation/derivation only).
- BLOCK_BYTES, 16, data bytes per frame.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 120000, maximum idle clocks between consecutive bytes inside a frame (10 ms at 12 MHz).

Ports:
- clk  in  1  system clock (CLK12M at top level).
- nrst  in  1  reset, asynchronous, active-low.
- received  in  1  single-cycle strobe from the UART: `rx_byte` is valid.
- rx_byte  in  8  received byte.
- recv_error  in  1  single-cycle UART framing-error strobe.
- block_valid  out  1  assembled block available.
- block_ready  in  1  consumer accepts the block.
- block_data  out  8*BLOCK_BYTES  assembled block; first data byte in MSBs.
- block_mode  out  1  0 = encrypt (mode byte 8'h00), 1 = decrypt (mode byte 8'h01).
- busy  out  1  high in any state other than IDLE.
- err_checksum  out  1  one-cycle pulse.
- err_timeout  out  1  one-cycle pulse.
- err_mode  out  1  one-cycle pulse.
- err_overrun  out  1  one-cycle pulse.
- err_framing  out  1  one-cycle pulse.

Behaviour:
- Reset: every output is 0, state is IDLE, checksum accumulator is 0, byte index is 0, timeout counter is 0. All of this applies asynchronously on nrst low. Reset mid-frame discards the partial block.
- All state changes occur on `received`, `recv_error`, the timeout expiring, or the handshake. `rx_byte` is sampled only when `received` = 1.
- IDLE:
  - Byte equal to SOF_BYTE -> MODE; clear the accumulator.
  - Any other byte is ignored silently.
- MODE:
  - Byte 8'h00 or 8'h01 -> latch `block_mode`, accumulator = byte, index = 0, go to DATA.
  - Any other byte -> `err_mode` pulse, go to IDLE.
- DATA:
  - Each byte shifts into `block_data` from the MSB side (byte 0 ends in [8*BLOCK_BYTES-1 -: 8]).
  - accumulator ^= byte; index increments.
  - After byte BLOCK_BYTES-1 -> CHECK.
- CHECK:
  - Byte == accumulator -> HOLD; `block_valid` rises the cycle after the `received` strobe (latency 1).
  - Byte != accumulator -> `err_checksum` pulse, go to IDLE; `block_valid` stays 0.
- HOLD:
  - `block_valid` = 1. `block_data` and `block_mode` are stable until the handshake.
  - `block_valid` && `block_ready` -> IDLE next cycle, `block_valid` drops.
  - Any `received` strobe in HOLD (including the handshake cycle) -> byte dropped, `err_overrun` pulse.
- Timeout (MODE, DATA, CHECK only):
  - The counter reloads to TIMEOUT_CYCLES-1 on every accepted byte and decrements otherwise.
  - Reaching 0 -> `err_timeout` pulse, go to IDLE.
  - `received` in the same cycle the counter reaches 0 -> the byte wins, the counter reloads, no timeout.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- `recv_error` in MODE, DATA, or CHECK -> `err_framing` pulse, go to IDLE.
- `recv_error` in IDLE or HOLD -> `err_framing` pulse only, no state change.
- If `recv_error` and `received` occur in the same cycle, `recv_error` takes priority and the byte is discarded.
- Error pulses last exactly one cycle. The pulse outputs are registered.

Decomposition:
- Shared package cipherbox_pkg holds:
  - state enum {IDLE, MODE, DATA, CHECK, HOLD};
  - SOF_BYTE default and mode codes MODE_ENC = 8'h00, MODE_DEC = 8'h01;
  - BLOCK_BITS = 128.
- One natural sub-module: inter_byte_timer. It is a loadable down-counter with reload, enable, and expire outputs, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Valid frame: send A5, 00, bytes 00..0F, then checksum 00^00^01^…^0F = 8'h00 -> `block_valid` one cycle later, `block_data` = 128'h000102030405060708090A0B0C0D0E0F, `block_mode` = 0. With `block_ready` held low for 50 cycles, the outputs stay stable. On `block_ready` = 1, return to IDLE and `busy` = 0.
- Bad checksum: same frame with final byte 8'h01 -> `err_checksum` pulse one cycle, `block_valid` never asserts, IDLE.
- Mode and sync: send 55, 55, A5, 07 -> the 55 bytes are ignored; `err_mode` pulses after the 07; the next A5, 01, … frame is parsed with `block_mode` = 1.
- Timeout: send A5, 00, then 5 data bytes, then idle TIMEOUT_CYCLES cycles -> `err_timeout` pulse exactly TIMEOUT_CYCLES cycles after the 5th strobe, IDLE. A byte strobed on the expiry cycle instead prevents the timeout.
- Overrun and framing:
  - In HOLD, strobe `received` with 8'hA5 -> `err_overrun` pulse; the block is unchanged.
  - Mid-DATA, strobe `recv_error` together with `received` -> `err_framing` pulse, the byte is discarded, IDLE.
- Async reset: assert nrst low for 3 ns mid-DATA, between clock edges -> all outputs 0 immediately. After release, a full valid frame assembles correctly.
